control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit driving the Datapath's per-step control inputs. Each instruction is sequenced through fetch (T0–T2) and an opcode-dependent execute tail (T3–T7). The block sits directly upstream of the Datapath and replaces the hand-written per-state signal lists used in the datapath benches. It reads the instruction register and issues one control word per clock cycle.

## Interface
Parameters
- OPW, 5, opcode width; opcode is IR[31:32-OPW]

Ports
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  synchronous, active-high reset; shared with the Datapath
- IR  in  32  instruction register contents from the Datapath; opcode = IR[31:27]
- Run  out  1  high while executing; low in HALT
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR controls
- MDRin, MDRout, MDMuxread, RAMread, RAMwrite  out  1 each  memory-path controls
- IRin, Yin, Zlowin, Zlowout, CSEout  out  1 each  register/bus controls
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/enable
- ADD, SUB, AND, OR  out  1 each  ALU operation selects

Datapath controls not listed above (HI/LO, Zhigh, ports, shifts, MUL/DIV, CONin) are tied low at the top level.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- Outputs are Moore outputs, decoded from the state and from IR[31:27] for T3–T7. Every output not listed for a state is 0.
- Each state lasts exactly one clock. The Datapath captures on the edge that ends the state.

Fetch (all opcodes)
- T0: PCout, MARin, IncPC, Zlowin
- T1: Zlowout, PCin, MDMuxread, RAMread, MDRin
- T2: MDRout, IRin

Execute tails (decoded from the IR loaded at the end of T2)
- ld 00000: T3 Grb BAout Yin; T4 CSEout ADD Zlowin; T5 Zlowout MARin; T6 MDMuxread RAMread MDRin; T7 MDRout Gra Rin; then T0.
- ldi 00001: T3 Grb BAout Yin; T4 CSEout ADD Zlowin; T5 Zlowout Gra Rin; then T0.
- st 00010: T3 Grb BAout Yin; T4 CSEout ADD Zlowin; T5 Zlowout MARin; T6 Gra Rout MDRin (MDMuxread=0); T7 RAMwrite; then T0.
- add/sub/and/or 00011/00100/00101/00110: T3 Grb Rout Yin; T4 Grc Rout op Zlowin; T5 Zlowout Gra Rin; then T0.
- addi/andi/ori 01100/01101/01110: T3 Grb Rout Yin; T4 CSEout op Zlowin; T5 Zlowout Gra Rin; then T0.
- nop 11010 and every undefined opcode: T2 -> T0 directly, with no execute tail.
- halt 11011: T2 -> HALT. In HALT all controls are 0 and Run=0. HALT is left only via clear.

Reset
- clear=1 at any rising edge forces state RST, regardless of the current state (including mid-instruction and HALT).
- In RST all controls are 0 and Run=0.
- The first rising edge with clear=0 moves RST -> T0; Run=1 from T0 onward.
- An instruction interrupted by clear is abandoned, not resumed. A partially completed st never asserts RAMwrite after clear.

## Timing
- Instruction length in cycles: fetch 3; nop/undefined 3; ldi/addi/andi/ori/ALU-reg 6; ld/st 8; halt 3 then stays in HALT.
- Exactly one of ADD/SUB/AND/OR is high in T4 of an arithmetic tail; none are high elsewhere.
- RAMread is high only in T1 and ld-T6. RAMwrite is high only in st-T7.
- IR is sampled combinationally during T3–T7. IR must remain stable from the end of T2 to the return to T0; IRin is asserted only in T2.
- No two bus drivers are high in the same state (PCout, Zlowout, MDRout, Rout, BAout, CSEout). Verification asserts this every cycle.

## Test plan
- Reset: hold clear for 3 cycles, then release -> all controls 0 and Run=0 while clear is high; T0 controls appear on the first cycle after release.
- ldi R4,0xA then addi R3,R4,-5 (memory 0: ldi, 1: addi), Datapath attached -> 12 cycles after T0; R4=0x0000000A and R3=0x00000005; PC=2.
- ld R1,0x55 with mem[0x55]=0x1234 -> R1=0x00001234 after 8 cycles. Then st 0x60,R1 -> RAMwrite pulses once in st-T7 and mem[0x60]=0x1234.
- ALU-reg: R2=6, R3=3; sub R1,R2,R3 then or R5,R2,R3 -> R1=3, R5=7; SUB high only in the first instruction's T4, OR only in the second's.
- Undefined opcode 11111, then halt -> the undefined opcode takes 3 cycles with no Rin/RAMwrite. After halt, Run=0 and outputs stay 0 for 20 cycles; clear restarts at T0.
- clear asserted during st-T6 -> next state RST; RAMwrite never asserts and the memory is unchanged.

Source files
------------

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control sequencer for the Datapath
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        Run,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDMuxread,
  output logic        RAMread,
  output logic        RAMwrite,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        CSEout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR
);

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  state_t         state, eff, next;
  logic [OPW-1:0] op;
  logic           is_ld, is_st, is_mem, is_alu, is_imm, is_halt, has_tail;
  logic           unused_ir;

  assign op        = IR[31:32-OPW];
  assign unused_ir = ^IR[31-OPW:0];

  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_mem   = is_ld || is_st || (op == OP_LDI);
  assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_imm   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_halt  = (op == OP_HALT);
  assign has_tail = is_mem || is_alu || is_imm;

  // The new IR is only visible after the T2 edge, so the first cycle after
  // T2 stands in for T0 (no tail) or HALT when the opcode has no execute tail.
  always_comb begin
    eff = state;
    if (state == T3 && !has_tail) eff = is_halt ? HALT : T0;
  end

  always_comb begin
    case (eff)
      RST:     next = T0;
      T0:      next = T1;
      T1:      next = T2;
      T2:      next = T3;
      T3:      next = T4;
      T4:      next = T5;
      T5:      next = (is_ld || is_st) ? T6 : T0;
      T6:      next = T7;
      T7:      next = T0;
      HALT:    next = HALT;
      default: next = RST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state <= RST;
    else       state <= next;
  end

  always_comb begin
    Run = (eff != RST) && (eff != HALT);
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite, IRin} = '0;
    {Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {ADD, SUB, AND, OR} = '0;
    case (eff)
      T0: {PCout, MARin, IncPC, Zlowin} = '1;
      T1: {Zlowout, PCin, MDMuxread, RAMread, MDRin} = '1;
      T2: {MDRout, IRin} = '1;
      T3: begin
        {Grb, Yin} = '1;
        if (is_mem) BAout = 1'b1;
        else        Rout  = 1'b1;
      end
      T4: begin
        Zlowin = 1'b1;
        if (is_alu) {Grc, Rout} = '1;
        else        CSEout = 1'b1;
        ADD = is_mem || (op == OP_ADD) || (op == OP_ADDI);
        SUB = (op == OP_SUB);
        AND = (op == OP_AND) || (op == OP_ANDI);
        OR  = (op == OP_OR) || (op == OP_ORI);
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_ld || is_st) MARin = 1'b1;
        else                {Gra, Rin} = '1;
      end
      T6: begin
        MDRin = 1'b1;
        if (is_ld) {MDMuxread, RAMread} = '1;
        else       {Gra, Rout} = '1;
      end
      T7: begin
        if (is_ld) {MDRout, Gra, Rin} = '1;
        else       RAMwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = 32'd0;
  logic Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite, IRin;
  logic Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout, ADD, SUB, AND, OR;

  control_sequencer #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .IR(IR), .Run(Run),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .MDMuxread(MDMuxread), .RAMread(RAMread),
    .RAMwrite(RAMwrite), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .Zlowout(Zlowout), .CSEout(CSEout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR)
  );

  always #5 clock = ~clock;

  localparam logic [24:0] RUN = 25'd1 << 24, PCOUT = 25'd1 << 23, PCIN = 25'd1 << 22;
  localparam logic [24:0] INCPC = 25'd1 << 21, MARIN = 25'd1 << 20, MDRIN = 25'd1 << 19;
  localparam logic [24:0] MDROUT = 25'd1 << 18, MDMUX = 25'd1 << 17, RAMRD = 25'd1 << 16;
  localparam logic [24:0] RAMWR = 25'd1 << 15, IRIN = 25'd1 << 14, YIN = 25'd1 << 13;
  localparam logic [24:0] ZLIN = 25'd1 << 12, ZLOUT = 25'd1 << 11, CSE = 25'd1 << 10;
  localparam logic [24:0] GRA = 25'd1 << 9, GRB = 25'd1 << 8, GRC = 25'd1 << 7;
  localparam logic [24:0] RIN = 25'd1 << 6, ROUT = 25'd1 << 5, BAOUT = 25'd1 << 4;
  localparam logic [24:0] A_ADD = 25'd1 << 3, A_SUB = 25'd1 << 2, A_AND = 25'd1 << 1, A_OR = 25'd1;

  logic [24:0] word;
  logic [5:0]  drivers;
  assign word = {Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite,
                 IRin, Yin, Zlowin, Zlowout, CSEout, Gra, Grb, Grc, Rin, Rout, BAout,
                 ADD, SUB, AND, OR};
  assign drivers = {PCout, Zlowout, MDRout, Rout, BAout, CSEout};

  logic [24:0] exp_q[$];
  logic [31:0] next_ir;
  int          checks = 0;
  int          errors = 0;
  int          ramwrite_pulses = 0;

  always @(negedge clock) if (RAMwrite === 1'b1) ramwrite_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push_instr(input logic [4:0] op);
    exp_q.push_back(RUN | PCOUT | MARIN | INCPC | ZLIN);
    exp_q.push_back(RUN | ZLOUT | PCIN | MDMUX | RAMRD | MDRIN);
    exp_q.push_back(RUN | MDROUT | IRIN);
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        exp_q.push_back(RUN | GRB | BAOUT | YIN);
        exp_q.push_back(RUN | CSE | A_ADD | ZLIN);
        if (op == 5'b00001) exp_q.push_back(RUN | ZLOUT | GRA | RIN);
        else exp_q.push_back(RUN | ZLOUT | MARIN);
        if (op == 5'b00000) begin
          exp_q.push_back(RUN | MDMUX | RAMRD | MDRIN);
          exp_q.push_back(RUN | MDROUT | GRA | RIN);
        end else if (op == 5'b00010) begin
          exp_q.push_back(RUN | GRA | ROUT | MDRIN);
          exp_q.push_back(RUN | RAMWR);
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        exp_q.push_back(RUN | GRB | ROUT | YIN);
        exp_q.push_back(RUN | GRC | ROUT | ZLIN |
                        (op == 5'b00011 ? A_ADD : op == 5'b00100 ? A_SUB :
                         op == 5'b00101 ? A_AND : A_OR));
        exp_q.push_back(RUN | ZLOUT | GRA | RIN);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        exp_q.push_back(RUN | GRB | ROUT | YIN);
        exp_q.push_back(RUN | CSE | ZLIN |
                        (op == 5'b01100 ? A_ADD : op == 5'b01101 ? A_AND : A_OR));
        exp_q.push_back(RUN | ZLOUT | GRA | RIN);
      end
      default: ;
    endcase
  endtask

  task automatic step(input string tag, input bit clr);
    logic [24:0] want;
    logic        irin;
    @(negedge clock);
    want = exp_q.pop_front();
    check(tag, {7'd0, word}, {7'd0, want});
    check("bus_drivers_onehot0", {31'd0, ($countones(drivers) <= 1)}, 32'd1);
    irin = IRin;
    clear = clr;
    @(posedge clock);
    #1;
    if (irin) IR = next_ir;
  endtask

  task automatic run_instr(input logic [4:0] op);
    next_ir = {op, 27'($urandom)};
    push_instr(op);
    while (exp_q.size() > 0) step($sformatf("op_%05b", op), 1'b0);
  endtask

  logic [4:0] prog[$] = '{5'b00001, 5'b01100, 5'b00000, 5'b00010, 5'b00100, 5'b00110,
                          5'b00011, 5'b00101, 5'b01101, 5'b01110, 5'b11010, 5'b11111};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    @(posedge clock);
    #1;
    repeat (3) exp_q.push_back(25'd0);
    step("reset", 1'b1);
    step("reset", 1'b1);
    step("reset", 1'b0);

    foreach (prog[i]) run_instr(prog[i]);

    run_instr(5'b11011);
    repeat (20) begin
      exp_q.push_back(25'd0);
      step("halt", 1'b0);
    end
    exp_q.push_back(25'd0);
    step("halt_clear", 1'b1);
    exp_q.push_back(25'd0);
    step("rst_after_halt", 1'b0);
    run_instr(5'b00001);

    // Interrupt a store in T6; the T7 write must never happen.
    next_ir = {5'b00010, 27'($urandom)};
    push_instr(5'b00010);
    repeat (6) step("st_abort", 1'b0);
    step("st_abort_t6", 1'b1);
    exp_q.delete();
    exp_q.push_back(25'd0);
    step("rst_after_abort", 1'b0);
    run_instr(5'b11010);
    run_instr(5'b00011);

    check("ramwrite_pulses", ramwrite_pulses, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
